// File: rtl/ksz8851_pkg.sv
// Shared KSZ8851 register map, bit masks and transmit-sequencer types.
package ksz8851_pkg;

  localparam logic [7:0] REG_TXMIR = 8'h78;
  localparam logic [7:0] REG_TXQCR = 8'h80;
  localparam logic [7:0] REG_RXQCR = 8'h82;
  localparam logic [7:0] REG_IER   = 8'h90;

  localparam logic [15:0] SDA_MASK   = 16'h0008;
  localparam logic [15:0] METFE_MASK = 16'h0001;
  localparam logic [15:0] TXIC_CTRL  = 16'h8000;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NO_MEM  = 2'b01;
  localparam logic [1:0] ERR_BAD_LEN = 2'b10;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_RD_TXMIR,
    ST_CHK_MEM,
    ST_GAP,
    ST_WR_IER0,
    ST_RD_RXQCR,
    ST_SET_SDA,
    ST_WR_CTRL,
    ST_WR_BCNT,
    ST_WR_DATA,
    ST_RD_RXQCR2,
    ST_CLR_SDA,
    ST_RD_TXQCR,
    ST_SET_METFE,
    ST_WR_IER,
    ST_DONE,
    ST_ERR
  } tx_state_e;

  // One register-bus access as presented to the bus engine
  typedef struct packed {
    logic        wr;
    logic [7:0]  offset;
    logic        dummy;
    logic [15:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/ksz_tx_sequencer_if.sv
// Payload stream plus register-bus engine handshake for the transmit sequencer.
interface ksz_tx_sequencer_if;

  logic [15:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;

  logic        bus_req;
  logic        bus_wr;
  logic [7:0]  bus_offset;
  logic        bus_dummy;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_done;

  modport master (
    input  pl_data, pl_valid, bus_rdata, bus_done,
    output pl_ready, bus_req, bus_wr, bus_offset, bus_dummy, bus_wdata
  );

  modport slave (
    output pl_data, pl_valid, bus_rdata, bus_done,
    input  pl_ready, bus_req, bus_wr, bus_offset, bus_dummy, bus_wdata
  );

endinterface

// File: rtl/ksz_tx_sequencer.sv
// Re-triggerable KSZ8851 transmit sequencer: TXQ memory check with retry,
// IER/SDA bracketing, payload streaming with dword padding and manual enqueue.
module ksz_tx_sequencer
  import ksz8851_pkg::*;
#(
  parameter int unsigned LEN_W       = 13,
  parameter int unsigned MAX_LEN     = 1514,
  parameter int unsigned MAX_RETRY   = 8,
  parameter int unsigned RETRY_GAP   = 64,
  parameter logic [15:0] IER_RESTORE = 16'hEB00
) (
  input  logic             clk40m,
  input  logic             reset,
  input  logic             tx_start,
  input  logic [LEN_W-1:0] tx_len,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_err,
  output logic [1:0]       tx_err_code,
  ksz_tx_sequencer_if.master bus
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int unsigned GAP_W   = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  tx_state_e          state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   wcnt_q;
  logic [LEN_W-1:0]   dcnt_q;
  logic [RETRY_W-1:0] retry_q;
  logic [GAP_W-1:0]   gap_q;
  logic [15:0]        rdata_q;

  logic [LEN_W:0]     need_c;
  logic [LEN_W:0]     round_c;
  logic [LEN_W:0]     half_c;
  logic               mem_ok_c;
  logic               len_bad_c;
  bus_cmd_t           cmd_c;
  tx_state_e          next_c;

  // Free-memory threshold, dword-rounded word total and payload word count
  assign need_c    = {1'b0, len_q} + (LEN_W+1)'(4);
  assign mem_ok_c  = (LEN_W+1)'(rdata_q[12:0]) >= need_c;
  assign round_c   = ({1'b0, len_q} + (LEN_W+1)'(3)) & ~(LEN_W+1)'(3);
  assign half_c    = {1'b0, len_q} + (LEN_W+1)'(1);
  assign len_bad_c = (tx_len == '0) || (32'(tx_len) > MAX_LEN);

  // Access issued by each single-shot bus state and where it leads on completion
  always_comb begin
    cmd_c  = '0;
    next_c = ST_IDLE;
    case (state)
      ST_RD_TXMIR:  begin cmd_c.offset = REG_TXMIR; next_c = ST_CHK_MEM; end
      ST_WR_IER0:   begin cmd_c.wr = 1'b1; cmd_c.offset = REG_IER; next_c = ST_RD_RXQCR; end
      ST_RD_RXQCR:  begin cmd_c.offset = REG_RXQCR; next_c = ST_SET_SDA; end
      ST_SET_SDA:   begin
        cmd_c.wr = 1'b1; cmd_c.offset = REG_RXQCR; cmd_c.wdata = rdata_q | SDA_MASK;
        next_c = ST_WR_CTRL;
      end
      ST_WR_CTRL:   begin
        cmd_c.wr = 1'b1; cmd_c.dummy = 1'b1; cmd_c.wdata = TXIC_CTRL; next_c = ST_WR_BCNT;
      end
      ST_WR_BCNT:   begin
        cmd_c.wr = 1'b1; cmd_c.dummy = 1'b1; cmd_c.wdata = 16'(len_q); next_c = ST_WR_DATA;
      end
      ST_RD_RXQCR2: begin cmd_c.offset = REG_RXQCR; next_c = ST_CLR_SDA; end
      ST_CLR_SDA:   begin
        cmd_c.wr = 1'b1; cmd_c.offset = REG_RXQCR; cmd_c.wdata = rdata_q & ~SDA_MASK;
        next_c = ST_RD_TXQCR;
      end
      ST_RD_TXQCR:  begin cmd_c.offset = REG_TXQCR; next_c = ST_SET_METFE; end
      ST_SET_METFE: begin
        cmd_c.wr = 1'b1; cmd_c.offset = REG_TXQCR; cmd_c.wdata = rdata_q | METFE_MASK;
        next_c = ST_WR_IER;
      end
      ST_WR_IER:    begin
        cmd_c.wr = 1'b1; cmd_c.offset = REG_IER; cmd_c.wdata = IER_RESTORE; next_c = ST_DONE;
      end
      default: ;
    endcase
  end

  // Sequencer state, counters and all registered outputs
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      len_q          <= '0;
      wcnt_q         <= '0;
      dcnt_q         <= '0;
      retry_q        <= '0;
      gap_q          <= '0;
      rdata_q        <= '0;
      tx_busy        <= 1'b0;
      tx_done        <= 1'b0;
      tx_err         <= 1'b0;
      tx_err_code    <= ERR_NONE;
      bus.pl_ready   <= 1'b0;
      bus.bus_req    <= 1'b0;
      bus.bus_wr     <= 1'b0;
      bus.bus_offset <= '0;
      bus.bus_dummy  <= 1'b0;
      bus.bus_wdata  <= '0;
    end else begin
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
      bus.pl_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            if (len_bad_c) begin
              state       <= ST_ERR;
              tx_err      <= 1'b1;
              tx_err_code <= ERR_BAD_LEN;
            end else begin
              state       <= ST_RD_TXMIR;
              len_q       <= tx_len;
              retry_q     <= '0;
              tx_err_code <= ERR_NONE;
              tx_busy     <= 1'b1;
            end
          end
        end
        ST_CHK_MEM: begin
          if (mem_ok_c) begin
            state <= ST_WR_IER0;
          end else if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
            state       <= ST_ERR;
            tx_err      <= 1'b1;
            tx_err_code <= ERR_NO_MEM;
            tx_busy     <= 1'b0;
          end else begin
            retry_q <= retry_q + RETRY_W'(1);
            gap_q   <= GAP_W'(RETRY_GAP - 1);
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q == '0) state <= ST_RD_TXMIR;
          else             gap_q <= gap_q - GAP_W'(1);
        end
        // Payload words wait for pl_valid; pad words go out as zero without consuming
        ST_WR_DATA: begin
          if (!bus.bus_req) begin
            if (dcnt_q != '0) begin
              if (bus.pl_valid) begin
                bus.bus_req    <= 1'b1;
                bus.bus_wr     <= 1'b1;
                bus.bus_offset <= '0;
                bus.bus_dummy  <= 1'b1;
                bus.bus_wdata  <= bus.pl_data;
                bus.pl_ready   <= 1'b1;
                dcnt_q         <= dcnt_q - LEN_W'(1);
              end
            end else begin
              bus.bus_req    <= 1'b1;
              bus.bus_wr     <= 1'b1;
              bus.bus_offset <= '0;
              bus.bus_dummy  <= 1'b1;
              bus.bus_wdata  <= '0;
            end
          end else if (bus.bus_done) begin
            bus.bus_req <= 1'b0;
            wcnt_q      <= wcnt_q - LEN_W'(1);
            if (wcnt_q == LEN_W'(1)) state <= ST_RD_RXQCR2;
          end
        end
        ST_DONE, ST_ERR: state <= ST_IDLE;
        default: begin
          if (!bus.bus_req) begin
            bus.bus_req    <= 1'b1;
            bus.bus_wr     <= cmd_c.wr;
            bus.bus_offset <= cmd_c.offset;
            bus.bus_dummy  <= cmd_c.dummy;
            bus.bus_wdata  <= cmd_c.wdata;
          end else if (bus.bus_done) begin
            bus.bus_req <= 1'b0;
            state       <= next_c;
            if (!cmd_c.wr) rdata_q <= bus.bus_rdata;
            if (state == ST_WR_BCNT) begin
              wcnt_q <= round_c[LEN_W:1];
              dcnt_q <= half_c[LEN_W:1];
            end
            if (state == ST_WR_IER) begin
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksz_tx_sequencer.sv
// Self-checking bench for ksz_tx_sequencer: bus-engine model with an access
// scoreboard, payload source, and one task per scenario.
module tb_ksz_tx_sequencer;
  import ksz8851_pkg::*;

  localparam int unsigned LEN_W = 13;

  typedef struct packed {
    logic        wr;
    logic [7:0]  off;
    logic        dummy;
    logic [15:0] wdata;
  } acc_t;

  logic             clk40m = 1'b0;
  logic             reset;
  logic             tx_start;
  logic [LEN_W-1:0] tx_len;
  logic             tx_busy, tx_done, tx_err;
  logic [1:0]       tx_err_code;

  ksz_tx_sequencer_if bus_if ();

  ksz_tx_sequencer #(
    .LEN_W(LEN_W), .MAX_LEN(1514), .MAX_RETRY(8), .RETRY_GAP(64), .IER_RESTORE(16'hEB00)
  ) dut (
    .clk40m(clk40m), .reset(reset), .tx_start(tx_start), .tx_len(tx_len),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err), .tx_err_code(tx_err_code),
    .bus(bus_if)
  );

  always #5 clk40m = ~clk40m;

  acc_t        exp_q[$];
  logic [15:0] pl_words[$];
  logic [15:0] regs[256];
  logic [15:0] txmir;
  int n_vec, n_err, n_acc, n_ready, pl_idx, pl_mode, gen;

  function automatic void push_acc(input logic wr, input logic [7:0] off,
                                   input logic dummy, input logic [15:0] wdata);
    acc_t a;
    a.wr = wr; a.off = off; a.dummy = dummy; a.wdata = wdata;
    exp_q.push_back(a);
  endfunction

  // Expected access list for a full frame, from the current register model
  function automatic void push_frame(input int len);
    logic [15:0] rx, tx;
    int words, dwords;
    rx = regs[8'h82];
    tx = regs[8'h80];
    words  = ((len + 3) / 4) * 2;
    dwords = (len + 1) / 2;
    push_acc(1'b0, 8'h78, 1'b0, 16'h0000);
    push_acc(1'b1, 8'h90, 1'b0, 16'h0000);
    push_acc(1'b0, 8'h82, 1'b0, 16'h0000);
    push_acc(1'b1, 8'h82, 1'b0, rx | 16'h0008);
    push_acc(1'b1, 8'h00, 1'b1, 16'h8000);
    push_acc(1'b1, 8'h00, 1'b1, 16'(len));
    for (int i = 0; i < words; i++)
      push_acc(1'b1, 8'h00, 1'b1, (i < dwords) ? pl_words[i] : 16'h0000);
    push_acc(1'b0, 8'h82, 1'b0, 16'h0000);
    push_acc(1'b1, 8'h82, 1'b0, (rx | 16'h0008) & ~16'h0008);
    push_acc(1'b0, 8'h80, 1'b0, 16'h0000);
    push_acc(1'b1, 8'h80, 1'b0, tx | 16'h0001);
    push_acc(1'b1, 8'h90, 1'b0, 16'hEB00);
  endfunction

  // Bus engine: scores each new access, answers after a random latency
  task automatic bus_model();
    acc_t got, e, now;
    int   cnt;
    bit   seen, ok;
    seen = 0; cnt = 0;
    bus_if.bus_done  = 1'b0;
    bus_if.bus_rdata = 16'h0000;
    forever begin
      @(negedge clk40m);
      now = {bus_if.bus_wr, bus_if.bus_offset, bus_if.bus_dummy, bus_if.bus_wdata};
      if (!reset) begin
        seen = 0;
        bus_if.bus_done = 1'b0;
      end else if (bus_if.bus_done) begin
        bus_if.bus_done = 1'b0;
        seen = 0;
        n_vec++;
        if (bus_if.bus_req !== 1'b0) begin
          n_err++;
          $display("FAIL req_after_done: bus_req=%b required 0", bus_if.bus_req);
        end
      end else if (seen) begin
        if (cnt == 0) begin
          n_vec++;
          if (bus_if.bus_req !== 1'b1 || now !== got) begin
            n_err++;
            $display("FAIL bus_stable: req=%b cmd=%h required req=1 cmd=%h", bus_if.bus_req, now, got);
          end
          bus_if.bus_rdata = (got.off == 8'h78) ? txmir : regs[got.off];
          bus_if.bus_done  = 1'b1;
        end else begin
          cnt--;
        end
      end else if (bus_if.bus_req === 1'b1) begin
        seen = 1;
        cnt  = $urandom_range(0, 2);
        got  = now;
        n_acc++;
        if (got.wr && !got.dummy) regs[got.off] = got.wdata;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bus_unexpected: wr=%b off=%h dummy=%b wdata=%h required no access",
                   got.wr, got.off, got.dummy, got.wdata);
        end else begin
          e  = exp_q.pop_front();
          ok = (got.wr === e.wr) && (got.dummy === e.dummy) &&
               (e.dummy || got.off === e.off) && (!e.wr || got.wdata === e.wdata);
          if (!ok) begin
            n_err++;
            $display("FAIL bus_access #%0d: wr=%b off=%h dummy=%b wdata=%h required wr=%b off=%h dummy=%b wdata=%h",
                     n_acc, got.wr, got.off, got.dummy, got.wdata, e.wr, e.off, e.dummy, e.wdata);
          end
        end
      end
    end
  endtask

  // Payload source: advances one word per pl_ready pulse
  task automatic source();
    int cyc, seen_gen;
    cyc = 0; seen_gen = -1;
    bus_if.pl_valid = 1'b0;
    bus_if.pl_data  = 16'h0000;
    forever begin
      @(negedge clk40m);
      cyc++;
      if (seen_gen != gen) begin
        seen_gen = gen; pl_idx = 0; n_ready = 0;
      end else if (bus_if.pl_ready === 1'b1) begin
        pl_idx++; n_ready++;
      end
      if (pl_idx < pl_words.size()) begin
        bus_if.pl_data  = pl_words[pl_idx];
        bus_if.pl_valid = (pl_mode == 0) || ((cyc / 3) % 2 == 0);
      end else begin
        bus_if.pl_data  = 16'h0000;
        bus_if.pl_valid = 1'b0;
      end
    end
  endtask

  task automatic load_payload(input int len, input int mode);
    pl_words.delete();
    for (int i = 0; i < (len + 1) / 2; i++) pl_words.push_back(16'($urandom));
    pl_mode = mode;
    gen++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk40m);
    n_vec++;
    if ({tx_busy, tx_done, tx_err} !== 3'b000) begin
      n_err++; $display("FAIL reset_status: busy/done/err=%b required 000", {tx_busy, tx_done, tx_err});
    end
    n_vec++;
    if (tx_err_code !== 2'b00) begin
      n_err++; $display("FAIL reset_code: %b required 00", tx_err_code);
    end
    n_vec++;
    if ({bus_if.bus_req, bus_if.bus_wr, bus_if.bus_dummy, bus_if.pl_ready} !== 4'b0000) begin
      n_err++; $display("FAIL reset_bus_ctl: req/wr/dummy/ready=%b required 0000",
                        {bus_if.bus_req, bus_if.bus_wr, bus_if.bus_dummy, bus_if.pl_ready});
    end
    n_vec++;
    if ({bus_if.bus_offset, bus_if.bus_wdata} !== 24'h0) begin
      n_err++; $display("FAIL reset_bus_data: off/wdata=%h required 0", {bus_if.bus_offset, bus_if.bus_wdata});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk40m);
  endtask

  // Full frame; poke >= 0 injects an (ignored) tx_start that many cycles in
  task automatic run_frame(input int len, input int mode, input int poke);
    int  lat, cyc;
    bit  err_seen, busy_drop, stray;
    load_payload(len, mode);
    push_frame(len);
    repeat (2) @(negedge clk40m);
    tx_len = LEN_W'(len); tx_start = 1'b1;
    @(negedge clk40m);
    tx_start = 1'b0;
    lat = 1;
    while (bus_if.bus_req !== 1'b1 && lat < 10) begin
      @(negedge clk40m); lat++;
    end
    n_vec++;
    if (lat != 2) begin
      n_err++; $display("FAIL start_latency len=%0d: %0d cycles required 2", len, lat);
    end
    cyc = 0; err_seen = 0; busy_drop = 0;
    while (tx_done !== 1'b1 && cyc < 20000) begin
      if (tx_err === 1'b1) err_seen = 1;
      if (tx_busy !== 1'b1) busy_drop = 1;
      tx_start = (cyc == poke);
      if (cyc == poke) tx_len = '0;
      @(negedge clk40m); cyc++;
    end
    tx_start = 1'b0;
    n_vec++;
    if (tx_done !== 1'b1) begin
      n_err++; $display("FAIL frame_timeout len=%0d: tx_done=%b required 1", len, tx_done);
    end
    n_vec++;
    if (tx_busy !== 1'b0 || busy_drop) begin
      n_err++; $display("FAIL busy_window len=%0d: busy at done=%b early_drop=%0d required 0/0", len, tx_busy, busy_drop);
    end
    n_vec++;
    if (err_seen || tx_err_code !== 2'b00) begin
      n_err++; $display("FAIL frame_err len=%0d: err_seen=%0d code=%b required 0/00", len, err_seen, tx_err_code);
    end
    @(negedge clk40m);
    n_vec++;
    if (tx_done !== 1'b0) begin
      n_err++; $display("FAIL done_pulse len=%0d: tx_done=%b required 0", len, tx_done);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL accesses_left len=%0d: %0d required 0", len, exp_q.size());
    end
    n_vec++;
    if (n_ready != (len + 1) / 2) begin
      n_err++; $display("FAIL pl_ready_count len=%0d: %0d required %0d", len, n_ready, (len + 1) / 2);
    end
    if (poke >= 0) begin
      stray = 0;
      repeat (30) begin
        @(negedge clk40m);
        if (bus_if.bus_req !== 1'b0 || tx_busy !== 1'b0) stray = 1;
      end
      n_vec++;
      if (stray) begin
        n_err++; $display("FAIL start_ignored: activity after frame=%0d required 0", stray);
      end
    end
  endtask

  task automatic test_no_mem();
    int   reads, low, cyc;
    logic prev;
    txmir = 16'h0030;
    load_payload(0, 0);
    for (int i = 0; i < 8; i++) push_acc(1'b0, 8'h78, 1'b0, 16'h0000);
    repeat (2) @(negedge clk40m);
    tx_len = LEN_W'(60); tx_start = 1'b1;
    @(negedge clk40m);
    tx_start = 1'b0;
    reads = 0; low = 0; prev = 1'b0; cyc = 0;
    while (tx_err !== 1'b1 && cyc < 3000) begin
      if (bus_if.bus_req === 1'b1 && !prev) begin
        if (reads > 0) begin
          n_vec++;
          if (low != 66) begin
            n_err++; $display("FAIL poll_spacing #%0d: %0d idle cycles required 66", reads, low);
          end
        end
        reads++;
      end
      if (bus_if.bus_req !== 1'b1) low++; else low = 0;
      prev = bus_if.bus_req;
      @(negedge clk40m); cyc++;
    end
    n_vec++;
    if (tx_err !== 1'b1 || tx_err_code !== 2'b01) begin
      n_err++; $display("FAIL no_mem_err: err=%b code=%b required 1/01", tx_err, tx_err_code);
    end
    n_vec++;
    if (reads != 8 || exp_q.size() != 0) begin
      n_err++; $display("FAIL no_mem_polls: %0d polls, %0d left required 8/0", reads, exp_q.size());
    end
    n_vec++;
    if (tx_busy !== 1'b0) begin
      n_err++; $display("FAIL no_mem_busy: %b required 0", tx_busy);
    end
    repeat (20) @(negedge clk40m);
    n_vec++;
    if (tx_err !== 1'b0 || tx_err_code !== 2'b01 || bus_if.bus_req !== 1'b0) begin
      n_err++; $display("FAIL no_mem_hold: err=%b code=%b req=%b required 0/01/0", tx_err, tx_err_code, bus_if.bus_req);
    end
    txmir = 16'h0800;
  endtask

  task automatic test_bad_len(input int len);
    bit req_seen;
    @(negedge clk40m);
    tx_len = LEN_W'(len); tx_start = 1'b1;
    @(negedge clk40m);
    tx_start = 1'b0;
    n_vec++;
    if (tx_err !== 1'b1 || tx_err_code !== 2'b10) begin
      n_err++; $display("FAIL bad_len %0d: err=%b code=%b required 1/10", len, tx_err, tx_err_code);
    end
    req_seen = 0;
    repeat (10) begin
      if (bus_if.bus_req !== 1'b0) req_seen = 1;
      @(negedge clk40m);
    end
    n_vec++;
    if (req_seen || tx_err !== 1'b0 || tx_err_code !== 2'b10) begin
      n_err++; $display("FAIL bad_len_after %0d: req_seen=%0d err=%b code=%b required 0/0/10",
                        len, req_seen, tx_err, tx_err_code);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    load_payload(60, 0);
    push_frame(60);
    repeat (2) @(negedge clk40m);
    tx_len = LEN_W'(60); tx_start = 1'b1;
    @(negedge clk40m);
    tx_start = 1'b0;
    cyc = 0;
    while (n_ready < 5 && cyc < 2000) begin
      @(negedge clk40m); cyc++;
    end
    n_vec++;
    if (n_ready < 5) begin
      n_err++; $display("FAIL reach_data_phase: %0d words required >=5", n_ready);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({tx_busy, tx_done, tx_err, tx_err_code, bus_if.pl_ready, bus_if.bus_req,
         bus_if.bus_wr, bus_if.bus_offset, bus_if.bus_dummy, bus_if.bus_wdata} !== 33'h0) begin
      n_err++; $display("FAIL mid_reset_outputs: busy=%b req=%b dummy=%b wdata=%h ready=%b required all 0",
                        tx_busy, bus_if.bus_req, bus_if.bus_dummy, bus_if.bus_wdata, bus_if.pl_ready);
    end
    exp_q.delete();
    repeat (3) @(negedge clk40m);
    reset = 1'b1;
    repeat (2) @(negedge clk40m);
    run_frame(60, 0, -1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_acc = 0; n_ready = 0; pl_idx = 0; pl_mode = 0; gen = 0;
    tx_start = 1'b0; tx_len = '0; reset = 1'b0;
    txmir = 16'h0800;
    for (int i = 0; i < 256; i++) regs[i] = 16'h0000;
    regs[8'h82] = 16'h0030;
    regs[8'h80] = 16'h0002;
    fork
      bus_model();
      source();
    join_none
    test_reset();
    run_frame(60, 0, -1);
    run_frame(61, 0, -1);
    test_no_mem();
    test_bad_len(0);
    test_bad_len(1515);
    run_frame(61, 1, -1);
    test_reset_mid_frame();
    run_frame(8, 0, 20);
    run_frame(2, 1, -1);
    run_frame(1514, 0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
